// File: rtl/pipe_pkg.sv
// Shared widths, control-bit indices and the ID/EX payload type for the 8-bit core.
package pipe_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned CNT_W  = 16;

  // Control bundle bit map
  localparam int unsigned REG_WRITE  = 0;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_WRITE  = 2;
  localparam int unsigned ALU_SRC    = 3;
  localparam int unsigned MEM_TO_REG = 4;
  localparam int unsigned BRANCH     = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [IMM_W-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard: a load in EX whose destination is read by the decode slot.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs_used,
  input  logic              id_rd_used,
  output logic              hz_c
);

  // Register 0 is an ordinary register here, so address 0 matches like any other.
  assign hz_c = ex_valid & ex_mem_read & id_valid &
                ((id_rs_used & (id_rs == ex_wreg)) | (id_rd_used & (id_rd == ex_wreg)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and branch flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs_used,
  input  logic              id_rd_used,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic              stall
);

  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   hz_c;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl[MEM_READ]),
    .ex_wreg     (ex_q.wreg),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rd       (id_rd),
    .id_rs_used  (id_rs_used),
    .id_rd_used  (id_rd_used),
    .hz_c        (hz_c)
  );

  assign stall = ~reset & (hz_c | ex_hold);

  // Next-state: hold (flush still kills the slot), then flush/bubble, then capture.
  always_comb begin
    ex_d = ex_q;
    if (ex_hold) begin
      if (flush) begin
        ex_d.valid = 1'b0;
        ex_d.ctrl  = '0;
      end
    end else if (flush || hz_c) begin
      ex_d = '0;
    end else begin
      ex_d.valid = id_valid;
      ex_d.rs    = id_rs;
      ex_d.rd    = id_rd;
      ex_d.wreg  = id_wreg;
      ex_d.data1 = rf_data1;
      ex_d.data2 = rf_data2;
      ex_d.imm   = id_imm;
      ex_d.ctrl  = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_rs    = ex_q.rs;
  assign ex_rd    = ex_q.rd;
  assign ex_wreg  = ex_q.wreg;
  assign ex_data1 = ex_q.data1;
  assign ex_data2 = ex_q.data2;
  assign ex_imm   = ex_q.imm;
  assign ex_ctrl  = ex_q.ctrl;

`ifdef HAZARD_STATS_EN
  // Saturating counters; a stall only counts when the bubble is actually inserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz_c && !flush && !ex_hold && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubble, flush/hold priority, reset mid-stall.
// With HAZARD_STATS_EN defined it also checks the event counters.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rd, id_wreg;
  logic              id_rs_used, id_rd_used;
  logic [IMM_W-1:0]  id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] rf_data1, rf_data2;
  logic              ex_hold, flush;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs, ex_rd, ex_wreg;
  logic [DATA_W-1:0] ex_data1, ex_data2;
  logic [IMM_W-1:0]  ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rd_used(id_rd_used), .id_wreg(id_wreg), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2), .ex_hold(ex_hold),
    .flush(flush), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
`ifdef HAZARD_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_AW-1:0] rs, input logic rs_u,
                       input logic [REG_AW-1:0] rd, input logic rd_u,
                       input logic [REG_AW-1:0] wr, input logic [CTRL_W-1:0] ctrl,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input logic [IMM_W-1:0] imm);
    id_valid = v; id_rs = rs; id_rs_used = rs_u; id_rd = rd; id_rd_used = rd_u;
    id_wreg = wr; id_ctrl = ctrl; rf_data1 = d1; rf_data2 = d2; id_imm = imm;
    #1;
  endtask

  // Load to wreg 3, then a dependent ALU op: one bubble edge, one capture edge.
  task automatic load_use();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b010011, 8'h01, 8'h02, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 3'd4, 6'b000001, 8'h03, 8'h04, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    // Reset with every input nonzero, EX hold asserted
    reset = 1'b1; ex_hold = 1'b1; flush = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 6'b111111, 8'hFF, 8'hEE, 8'hDD);
    tick(); tick();
    check("rst_valid", 32'(ex_valid), 32'h0);
    check("rst_ctrl",  32'(ex_ctrl),  32'h0);
    check("rst_data1", 32'(ex_data1), 32'h0);
    check("rst_wreg",  32'(ex_wreg),  32'h0);
    check("rst_stall", 32'(stall),    32'h0);

    // Plain capture
    reset = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd4, 6'b000001, 8'h11, 8'h22, 8'h5A);
    check("cap_stall_pre", 32'(stall), 32'h0);
    tick();
    check("cap_data1", 32'(ex_data1), 32'h11);
    check("cap_data2", 32'(ex_data2), 32'h22);
    check("cap_ctrl",  32'(ex_ctrl),  32'h01);
    check("cap_valid", 32'(ex_valid), 32'h1);
    check("cap_imm",   32'(ex_imm),   32'h5A);
    check("cap_regs",  32'({ex_rs, ex_rd, ex_wreg}), 32'({3'd1, 3'd2, 3'd4}));

    // Load-use on rs: one bubble, then capture
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b010011, 8'h00, 8'h00, 8'h00);
    tick();
    check("ld_ctrl", 32'(ex_ctrl), 32'h13);
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 3'd6, 6'b000001, 8'h33, 8'h44, 8'h00);
    check("lu_stall", 32'(stall), 32'h1);
    tick();
    check("lu_bub_valid", 32'(ex_valid), 32'h0);
    check("lu_bub_ctrl",  32'(ex_ctrl),  32'h0);
    check("lu_stall_end", 32'(stall),    32'h0);
    tick();
    check("lu_cap_valid", 32'(ex_valid), 32'h1);
    check("lu_cap_data1", 32'(ex_data1), 32'h33);
    check("lu_cap_wreg",  32'(ex_wreg),  32'h6);

    // Load in EX, rs matches but unused, rd=5: no stall
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b000010, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b0, 3'd5, 1'b1, 3'd2, 6'b000001, 8'h55, 8'h66, 8'h00);
    check("nf_unused_stall", 32'(stall), 32'h0);
    // rd match while rs unused still stalls
    id_rd = 3'd3; #1;
    check("rd_match_stall", 32'(stall), 32'h1);
    // Invalid decode slot never stalls and is captured as a bubble
    id_valid = 1'b0; #1;
    check("inv_stall", 32'(stall), 32'h0);
    tick();
    check("inv_valid", 32'(ex_valid), 32'h0);
    check("inv_ctrl",  32'(ex_ctrl),  32'h0);

    // Non-load writing reg 3: no stall
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b000001, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd1, 6'b000001, 8'h00, 8'h00, 8'h00);
    check("nonload_stall", 32'(stall), 32'h0);

    // Register 0 is not special
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 6'b000010, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 3'd0, 1'b1, 3'd7, 1'b0, 3'd1, 6'b000001, 8'h00, 8'h00, 8'h00);
    check("r0_stall", 32'(stall), 32'h1);

    // Flush + hazard + hold together: slot killed, other fields held
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b000010, 8'hA5, 8'h5A, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd7, 6'b000001, 8'h99, 8'h88, 8'h00);
    flush = 1'b1; ex_hold = 1'b1; #1;
    check("fhh_stall", 32'(stall), 32'h1);
    tick();
    check("fhh_valid", 32'(ex_valid), 32'h0);
    check("fhh_ctrl",  32'(ex_ctrl),  32'h0);
    check("fhh_wreg",  32'(ex_wreg),  32'h3);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 1'b1, 3'd0, 1'b0, 3'd5, 6'b000001, 8'(i), 8'h00, 8'h00);
      check("hold_stall", 32'(stall), 32'h1);
      tick();
      check("hold_data1", 32'(ex_data1), 32'hA5);
      check("hold_wreg",  32'(ex_wreg),  32'h3);
      check("hold_valid", 32'(ex_valid), 32'h0);
    end
    ex_hold = 1'b0;

    // Reset mid-stall: stall drops at once, capture after release
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 6'b000010, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd2, 6'b000001, 8'h77, 8'h00, 8'h00);
    check("rms_stall_pre", 32'(stall), 32'h1);
    reset = 1'b1; #1;
    check("rms_stall_rst", 32'(stall), 32'h0);
    tick();
    check("rms_valid_rst", 32'(ex_valid), 32'h0);
    reset = 1'b0;
    tick();
    check("rms_cap_valid", 32'(ex_valid), 32'h1);
    check("rms_cap_data1", 32'(ex_data1), 32'h77);
    check("rms_cap_ctrl",  32'(ex_ctrl),  32'h01);

`ifdef HAZARD_STATS_EN
    check("cnt_stall_clr", 32'(stall_cnt), 32'h0);
    check("cnt_flush_clr", 32'(flush_cnt), 32'h0);
    for (int i = 0; i < 3; i++) load_use();
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1; tick(); flush = 1'b0;
    end
    check("cnt_stall", 32'(stall_cnt), 32'h3);
    check("cnt_flush", 32'(flush_cnt), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
